// File: rtl/tlb_pkg.sv
// Shared types, constants and the translation helper
// for the Sirius joint TLB.
package tlb_pkg;

  localparam int TLB_NENTRY = 16;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } tlb_state_e;

  typedef struct packed {
    logic [23:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_lo_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic        g;
    logic [7:0]  asid;
    tlb_lo_t     lo0;
    tlb_lo_t     lo1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        exc;
    logic [4:0]  code;
  } tlb_rsp_t;

  function automatic tlb_rsp_t translate(
    input logic [31:0] va,
    input logic        hit,
    input tlb_entry_t  e,
    input logic        st,
    input logic        k0u
  );
    tlb_rsp_t r;
    tlb_lo_t  lo;
    r  = '0;
    lo = va[12] ? e.lo1 : e.lo0;
    unique case (va[31:29])
      3'b100: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = k0u;
      end
      3'b101: begin
        r.paddr    = {3'b000, va[28:0]};
        r.uncached = 1'b1;
      end
      default: begin
        if (!hit || !lo.v) begin
          r.exc  = 1'b1;
          r.code = st ? EXC_TLBS : EXC_TLBL;
        end else if (st && !lo.d) begin
          r.exc  = 1'b1;
          r.code = EXC_MOD;
        end else begin
          r.paddr    = {lo.pfn[19:0], va[11:0]};
          r.uncached = (lo.c == 3'd2);
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative VPN2/ASID compare;
// lowest matching index wins.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int NENTRY = TLB_NENTRY
) (
  input  tlb_entry_t [NENTRY-1:0]  arr,
  input  logic [18:0]              vpn2,
  input  logic [7:0]               asid,
  output logic                     hit,
  output logic [$clog2(NENTRY)-1:0] idx
);

  localparam int IW = $clog2(NENTRY);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NENTRY - 1; i >= 0; i--) begin
      if (arr[i].vpn2 == vpn2 &&
          (arr[i].g || arr[i].asid == asid)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// 16-entry joint TLB: COP0 command FSM plus
// registered I/D translation ports.
module tlb_unit
  import tlb_pkg::*;
#(
  parameter int NENTRY = TLB_NENTRY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  output logic                      cmd_ready,
  output logic                      cmd_done,
  input  logic [85:0]               cp0_tlb_conf,
  input  logic [$clog2(NENTRY)-1:0] cp0_index,
  input  logic [$clog2(NENTRY)-1:0] cp0_random,
  input  logic [7:0]                curr_asid,
  input  logic                      kseg0_uncached,
  output logic [85:0]               cp0_tlb_conf_in,
  output logic                      miss_probe,
  output logic [$clog2(NENTRY)-1:0] matched_index_probe,
  input  logic                      i_req,
  input  logic [31:0]               i_vaddr,
  input  logic                      d_req,
  input  logic [31:0]               d_vaddr,
  input  logic                      d_store,
  output logic                      i_rsp_valid,
  output logic [31:0]               i_paddr,
  output logic                      i_uncached,
  output logic                      i_exc,
  output logic [4:0]                i_exc_code,
  output logic                      d_rsp_valid,
  output logic [31:0]               d_paddr,
  output logic                      d_uncached,
  output logic                      d_exc,
  output logic [4:0]                d_exc_code
);

  localparam int IW = $clog2(NENTRY);

  tlb_entry_t [NENTRY-1:0] arr;
  tlb_state_e              state;
  tlb_op_e                 op_q;
  tlb_entry_t              conf_q;
  logic [IW-1:0]           index_q;
  logic [IW-1:0]           random_q;
  logic [7:0]              asid_q;

  logic          i_hit, d_hit, p_hit;
  logic [IW-1:0] i_idx, d_idx, p_idx;
  tlb_rsp_t      i_nx, d_nx;

  tlb_match #(.NENTRY(NENTRY)) u_match_i (
    .arr  (arr),
    .vpn2 (i_vaddr[31:13]),
    .asid (curr_asid),
    .hit  (i_hit),
    .idx  (i_idx)
  );

  tlb_match #(.NENTRY(NENTRY)) u_match_d (
    .arr  (arr),
    .vpn2 (d_vaddr[31:13]),
    .asid (curr_asid),
    .hit  (d_hit),
    .idx  (d_idx)
  );

  tlb_match #(.NENTRY(NENTRY)) u_match_p (
    .arr  (arr),
    .vpn2 (conf_q.vpn2),
    .asid (asid_q),
    .hit  (p_hit),
    .idx  (p_idx)
  );

  // The I port never stores, so it can never raise Mod.
  assign i_nx = translate(i_vaddr, i_hit, arr[i_idx],
                          1'b0, kseg0_uncached);
  assign d_nx = translate(d_vaddr, d_hit, arr[d_idx],
                          d_store, kseg0_uncached);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      cmd_ready           <= 1'b1;
      cmd_done            <= 1'b0;
      op_q                <= OP_TLBR;
      conf_q              <= '0;
      index_q             <= '0;
      random_q            <= '0;
      asid_q              <= '0;
      arr                 <= '0;
      cp0_tlb_conf_in     <= '0;
      miss_probe          <= 1'b0;
      matched_index_probe <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state     <= S_EXEC;
            cmd_ready <= 1'b0;
            op_q      <= tlb_op_e'(cmd_op);
            conf_q    <= cp0_tlb_conf;
            index_q   <= cp0_index;
            random_q  <= cp0_random;
            asid_q    <= curr_asid;
          end
        end
        S_EXEC: begin
          state    <= S_DONE;
          cmd_done <= 1'b1;
          unique case (op_q)
            OP_TLBR:  cp0_tlb_conf_in <= arr[index_q];
            OP_TLBWI: arr[index_q]    <= conf_q;
            OP_TLBWR: arr[random_q]   <= conf_q;
            OP_TLBP: begin
              miss_probe          <= !p_hit;
              matched_index_probe <= p_hit ? p_idx : '0;
            end
          endcase
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_done  <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      {i_paddr, i_uncached, i_exc, i_exc_code} <= '0;
      {d_paddr, d_uncached, d_exc, d_exc_code} <= '0;
    end else begin
      i_rsp_valid <= i_req;
      d_rsp_valid <= d_req;
      if (i_req)
        {i_paddr, i_uncached, i_exc, i_exc_code} <= i_nx;
      if (d_req)
        {d_paddr, d_uncached, d_exc, d_exc_code} <= d_nx;
    end
  end

endmodule
